// File: rtl/serial_compliment_rx.sv
// Bit-serial receive-side two's complementer: LSB-first frames in, parallel
// two's-complement word out with a one-cycle valid pulse and zero/overflow flags.
module serial_compliment_rx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             set,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_bit,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic             seen_one;
    logic [WIDTH-1:0] sr;

    logic             restart;
    logic             accept;
    logic             last;
    logic             seen_cur;
    logic             seen_next;
    logic             obit;
    logic [WIDTH-1:0] sr_next;

    // A frame marker restarts the complement rule from this bit, in either state.
    always_comb begin
        restart   = in_valid & in_first;
        accept    = in_valid & (in_first | (state == SHIFT));
        last      = in_valid & ~in_first & (state == SHIFT) &
                    (count == CNT_W'(WIDTH - 1));
        seen_cur  = restart ? 1'b0 : seen_one;
        obit      = seen_cur ? ~in_bit : in_bit;
        seen_next = seen_cur | in_bit;
        sr_next   = {obit, sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (set) begin
            state     <= IDLE;
            count     <= '0;
            seen_one  <= 1'b0;
            sr        <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            out_ovf   <= 1'b0;
            out_zero  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                sr       <= sr_next;
                seen_one <= seen_next;
                if (restart) begin
                    count <= CNT_W'(1);
                    state <= SHIFT;
                end else if (last) begin
                    count     <= '0;
                    state     <= IDLE;
                    out_word  <= sr_next;
                    out_valid <= 1'b1;
                    out_zero  <= ~seen_next;
                    out_ovf   <= in_bit & ~seen_one;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: doc/serial_compliment_rx.md
Name: serial_compliment_rx

Overview:
Bit-serial receive-side two's complementer. Accepts an LSB-first serial bitstream framed by a first-bit marker. Applies the serial two's-complement rule on the fly: pass bits through up to and including the first 1, invert every bit after it. Assembles the result into a parallel word and issues a one-cycle valid pulse with status flags. Sits opposite the parallel-in serial complementer, at the deserialising end of the same serial link.

Parameters:
WIDTH, 4, word length in bits (>= 2)
CNT_W, 3, counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  system clock, all logic on rising edge
set  input  1  synchronous active-high reset
in_valid  input  1  in_bit is valid this cycle
in_first  input  1  marks the LSB of a new frame; only meaningful with in_valid=1
in_bit  input  1  serial data, LSB first
out_word  output  WIDTH  two's complement of the received word; held between frames
out_valid  output  1  one-cycle pulse when out_word/flags update
out_ovf  output  1  input was most-negative (MSB=1, rest 0); result equals input
out_zero  output  1  input was all zeros
busy  output  1  frame in progress

Behaviour:
- Reset (set=1 at clk edge): out_word=0, out_valid=0, out_ovf=0, out_zero=0, busy=0, count=0, seen_one=0, shift reg=0, state IDLE. set has priority over all inputs; asserting it mid-frame discards the frame and produces no out_valid.
- States: IDLE, SHIFT.
- Accepted bit rule (in_valid=1): obit = seen_one ? ~in_bit : in_bit; seen_one_next = seen_one | in_bit; sr <= {obit, sr[WIDTH-1:1]}, so bit k lands at out bit k after WIDTH shifts.
- IDLE: in_valid without in_first is ignored. in_valid&in_first: seen_one cleared before applying the rule to this bit, count=1, go to SHIFT, busy=1.
- SHIFT: in_valid=0 stalls, nothing changes. in_valid&~in_first: accept bit, count+1. in_valid&in_first: abort the current frame and restart with this bit as the new LSB (count=1, seen_one recomputed from this bit only); no out_valid for the aborted frame.
- Completion: on the cycle the WIDTH-th bit is accepted, the next-edge registers load:
  - out_word = final shifted value
  - out_valid=1
  - out_zero = ~seen_one_next
  - out_ovf = in_bit & ~seen_one (last bit is the first 1)
  - state IDLE, busy=0
- Latency: out_valid is high in the cycle immediately after the last bit is sampled.
- out_valid lasts exactly one cycle. out_word and flags hold until the next completion or reset.
- Back-to-back frames: in_first with in_valid is accepted in the out_valid cycle (state already IDLE). Minimum frame period is WIDTH cycles, with no dead cycle.
- busy = (state==SHIFT).
- Arithmetic is modulo 2**WIDTH: 0 maps to 0, and 100..0 maps to itself with out_ovf=1.

Test Plan:
- Reset: hold set=1 for 2 cycles mid-activity -> out_word=0, out_valid=0, out_ovf=0, out_zero=0, busy=0.
- WIDTH=4, word 0101 sent LSB first as bits 1,0,1,0 on consecutive cycles -> one cycle after bit 4: out_word=1011, out_valid pulses once, out_ovf=0, out_zero=0; busy high for cycles 1-4 after first bit edge.
- Word 0000 -> out_word=0000, out_zero=1. Then word 1000 -> out_word=1000, out_ovf=1, out_zero=0.
- Word 0110 with in_valid low for 2 cycles between each bit -> out_word=1010. busy stays 1 throughout gaps, out_valid only after the 4th accepted bit.
- Abort: bits 1,1 of word 0011, then in_first with new word 0001 -> single out_valid, out_word=1111.
- Back-to-back: 0101 then 0010, second in_first in the out_valid cycle -> 1011 then 1110, four cycles apart. Separately, set=1 after 2 bits -> no out_valid, outputs 0.
